// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for the fetch and data-memory ports.
// One access in flight at a time; data wins unless a waiting fetch has hit its starvation limit.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ram_req,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ready
);

   localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

   state_t            state_reg, state_next;
   logic [SCNT_W-1:0] scnt_reg, scnt_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic              wen_reg, wen_next;

   logic d_req;
   logic grant_d;
   logic grant_i;

   assign d_req   = dREN | dWEN;
   assign grant_d = d_req && !(iREN && (scnt_reg == SCNT_MAX));
   assign grant_i = !grant_d && iREN;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_reg <= IDLE;
         scnt_reg  <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         wen_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         scnt_reg  <= scnt_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         wen_reg   <= wen_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      scnt_next  = scnt_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      wen_next   = wen_reg;
      case (state_reg)
         IDLE: begin
            if (grant_d) begin
               state_next = DBUSY;
               addr_next  = daddr;
               wdata_next = dstore;
               wen_next   = dWEN;
               // Only data grants taken while a fetch waits count toward starvation.
               if (!iREN)
                  scnt_next = '0;
               else if (scnt_reg != SCNT_MAX)
                  scnt_next = scnt_reg + SCNT_W'(1);
            end else if (grant_i) begin
               state_next = IBUSY;
               addr_next  = iaddr;
               wdata_next = '0;
               wen_next   = 1'b0;
               scnt_next  = '0;
            end else begin
               scnt_next = '0;
            end
         end
         IBUSY, DBUSY: begin
            if (ram_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ram_req   = (state_reg != IDLE);
      ram_wen   = wen_reg;
      ram_addr  = addr_reg;
      ram_wdata = wdata_reg;
      iwait     = iREN && !((state_reg == IBUSY) && ram_ready);
      dwait     = d_req && !((state_reg == DBUSY) && ram_ready);
      iload     = ram_rdata;
      dload     = ram_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: requesters and a RAM model drive it,
// a negedge monitor checks every completed access against a memory-level reference.
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic        dwait;
   logic [31:0] dload;
   logic        ram_req;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic        ram_ready = 1'b0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          d_at_issue;
      int          exp_svc;
   } ient_t;

   typedef struct {
      bit          w;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
   } dent_t;

   ient_t ifq[$];
   dent_t dfq[$];

   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];

   int checks = 0;
   int passes = 0;
   int i_comp = 0, d_comp = 0;
   int i_seen = 0, d_seen = 0;
   int lat = 2;
   int busy_cyc = 0;
   int exp_svc_next = -1;
   int i_auto_left = 0;
   bit d_auto = 0, rand_en = 0, spur_en = 0, force_spur = 0;

   function automatic logic [31:0] init_word(input int i);
      logic [31:0] wi;
      wi = i;
      return (i == 16) ? 32'h2402000A : 32'h1000_0000 + wi * 32'h0001_0101;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fetch_start(input logic [31:0] a);
      ient_t e;
      iREN  = 1'b1;
      iaddr = a;
      e.addr = a;
      e.data = ref_mem[a[9:2]];
      e.d_at_issue = d_comp;
      e.exp_svc = exp_svc_next;
      ifq.push_back(e);
   endtask

   task automatic data_start(input bit w, input bit both, input logic [31:0] a, input logic [31:0] wd);
      dent_t e;
      dWEN   = w;
      dREN   = !w || both;
      daddr  = a;
      dstore = wd;
      e.w    = w;
      e.addr = a;
      e.wd   = wd;
      e.rd   = ref_mem[a[9:2]];
      if (w) ref_mem[a[9:2]] = wd;
      dfq.push_back(e);
   endtask

   task automatic data_random();
      bit w;
      w = ($urandom % 2) == 1;
      if (w)
         data_start(1'b1, ($urandom % 4) == 0, 32'h200 + ($urandom % 128) * 4, $urandom);
      else
         data_start(1'b0, 1'b0, ($urandom % 256) * 4, 32'h0);
   endtask

   // One clock: retire completed requests, issue new ones, step the RAM model.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (i_comp != i_seen) begin
         i_seen = i_comp;
         iREN = 1'b0;
         if (i_auto_left > 0) begin
            i_auto_left--;
            fetch_start(($urandom % 128) * 4);
         end
      end
      if (d_comp != d_seen) begin
         d_seen = d_comp;
         dREN = 1'b0;
         dWEN = 1'b0;
         if (d_auto) data_random();
      end
      if (rand_en) begin
         if (!iREN && ($urandom % 3) == 0) fetch_start(($urandom % 128) * 4);
         if (!dREN && !dWEN && ($urandom % 3) == 0) data_random();
      end
      ram_ready = 1'b0;
      if (ram_req) begin
         busy_cyc++;
         if (busy_cyc == 1 && rand_en) lat = $urandom_range(1, 4);
         if (busy_cyc >= lat) begin
            ram_ready = 1'b1;
            ram_rdata = ram_mem[ram_addr[9:2]];
            if (ram_wen) ram_mem[ram_addr[9:2]] = ram_wdata;
         end
      end else begin
         busy_cyc = 0;
         if (force_spur || (spur_en && ($urandom % 4) == 0)) begin
            ram_ready  = 1'b1;
            ram_rdata  = $urandom;
            force_spur = 0;
         end
      end
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while ((ifq.size() != 0 || dfq.size() != 0 || iREN || dREN || dWEN) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         checks++;
         $display("FAIL %s: timeout with %0d fetch and %0d data pending, required 0", name, ifq.size(), dfq.size());
      end
   endtask

   // Monitor: every completion pops the matching expectation.
   initial begin
      ient_t ie;
      dent_t de;
      int    svc;
      forever begin
         @(negedge CLK);
         if (nRST) begin
            if (iREN && !iwait) begin
               if (ifq.size() == 0) begin
                  checks++;
                  $display("FAIL i_unexpected: fetch completion with queue size 0, required >0");
               end else begin
                  ie = ifq.pop_front();
                  check("iload", iload, ie.data);
                  check("i_ram_addr", ram_addr, ie.addr);
                  check("i_ram_wen", {31'b0, ram_wen}, 32'h0);
                  svc = d_comp - ie.d_at_issue;
                  if (ie.exp_svc >= 0) begin
                     check("i_data_services", svc, ie.exp_svc);
                  end else begin
                     checks++;
                     if (svc <= LIMIT + 1) passes++;
                     else $display("FAIL i_starve_bound: %0d data services while fetch waited, required <= %0d", svc, LIMIT + 1);
                  end
               end
               i_comp++;
            end
            if ((dREN || dWEN) && !dwait) begin
               if (dfq.size() == 0) begin
                  checks++;
                  $display("FAIL d_unexpected: data completion with queue size 0, required >0");
               end else begin
                  de = dfq.pop_front();
                  check("d_ram_addr", ram_addr, de.addr);
                  check("d_ram_wen", {31'b0, ram_wen}, {31'b0, de.w});
                  if (de.w) check("d_ram_wdata", ram_wdata, de.wd);
                  else check("dload", dload, de.rd);
               end
               d_comp++;
            end
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = init_word(i);
         ref_mem[i] = ram_mem[i];
      end

      // Reset state
      repeat (3) tick();
      check("rst_ram_req", {31'b0, ram_req}, 32'h0);
      check("rst_ram_wen", {31'b0, ram_wen}, 32'h0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_iwait", {31'b0, iwait}, 32'h0);
      check("rst_dwait", {31'b0, dwait}, 32'h0);
      nRST = 1'b1;
      tick();

      // Single fetch with RAM latency 2
      lat = 2;
      fetch_start(32'h40);
      tick();
      check("f_req_c1", {31'b0, ram_req}, 32'h1);
      check("f_addr_c1", ram_addr, 32'h40);
      check("f_wen_c1", {31'b0, ram_wen}, 32'h0);
      check("f_iwait_c1", {31'b0, iwait}, 32'h1);
      tick();
      check("f_req_c2", {31'b0, ram_req}, 32'h1);
      check("f_iwait_c2", {31'b0, iwait}, 32'h0);
      check("f_iload_c2", iload, 32'h2402000A);
      tick();
      check("f_req_c3", {31'b0, ram_req}, 32'h0);

      // Simultaneous fetch and data: data first, turnaround, then fetch
      lat = 1;
      exp_svc_next = 1;
      fetch_start(32'h80);
      exp_svc_next = -1;
      data_start(1'b0, 1'b0, 32'h100, 32'h0);
      tick();
      check("pri_addr_d", ram_addr, 32'h100);
      check("pri_dwait", {31'b0, dwait}, 32'h0);
      check("pri_iwait_d", {31'b0, iwait}, 32'h1);
      tick();
      check("pri_turnaround_req", {31'b0, ram_req}, 32'h0);
      check("pri_iwait_idle", {31'b0, iwait}, 32'h1);
      tick();
      check("pri_addr_i", ram_addr, 32'h80);
      check("pri_iwait_i", {31'b0, iwait}, 32'h0);
      tick();

      // Data write
      data_start(1'b1, 1'b0, 32'h200, 32'hDEADBEEF);
      tick();
      check("wr_wen", {31'b0, ram_wen}, 32'h1);
      check("wr_wdata", ram_wdata, 32'hDEADBEEF);
      check("wr_dwait", {31'b0, dwait}, 32'h0);
      tick();
      check("wr_req_after", {31'b0, ram_req}, 32'h0);

      // Starvation: two rounds of exactly LIMIT data services before each fetch
      tick();
      exp_svc_next = LIMIT;
      d_auto = 1;
      i_auto_left = 1;
      fetch_start(($urandom % 128) * 4);
      data_random();
      n = 0;
      while (i_seen < 4 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         checks++;
         $display("FAIL starve_timeout: %0d fetches retired, required 4", i_seen);
      end
      d_auto = 0;
      exp_svc_next = -1;
      drain("starve_drain", 50);

      // Reset during DBUSY abandons the access; the held request is re-granted
      lat = 8;
      data_start(1'b1, 1'b0, 32'h204, 32'h12345678);
      tick();
      tick();
      check("mid_req_busy", {31'b0, ram_req}, 32'h1);
      nRST = 1'b0;
      tick();
      check("mid_rst_req", {31'b0, ram_req}, 32'h0);
      check("mid_rst_addr", ram_addr, 32'h0);
      check("mid_rst_wen", {31'b0, ram_wen}, 32'h0);
      check("mid_rst_dwait", {31'b0, dwait}, 32'h1);
      nRST = 1'b1;
      lat = 1;
      drain("mid_rst_regrant", 20);
      data_start(1'b0, 1'b0, 32'h204, 32'h0);
      drain("mid_rst_readback", 20);

      // ram_ready in IDLE with no request is ignored
      tick();
      force_spur = 1;
      tick();
      check("spur_ready_seen", {31'b0, ram_ready}, 32'h1);
      check("spur_req", {31'b0, ram_req}, 32'h0);
      check("spur_iwait", {31'b0, iwait}, 32'h0);
      check("spur_dwait", {31'b0, dwait}, 32'h0);
      tick();
      check("spur_req_next", {31'b0, ram_req}, 32'h0);

      // Randomized traffic
      rand_en = 1;
      spur_en = 1;
      repeat (1500) tick();
      rand_en = 0;
      spur_en = 0;
      lat = 1;
      drain("random_drain", 300);
      tick();
      check("final_req", {31'b0, ram_req}, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the instruction-fetch port and the data-memory port of the pipelined CPU onto a single shared RAM port. Requests are serviced one at a time through a registered grant state machine. Data requests have priority, and a starvation counter bounds how long fetch can be held off. The block sits between the fetch and memory stages and the RAM model, and is the only master on the RAM port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (≥1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  instruction read request; held until iwait low
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  fetch not complete
- iload  out  DATA_W  fetched word; valid when iREN && !iwait
- dREN  in  1  data read request; held until dwait low
- dWEN  in  1  data write request; held until dwait low
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  write data
- dwait  out  1  data access not complete
- dload  out  DATA_W  read word; valid when dREN && !dwait
- ram_req  out  1  RAM access active
- ram_wen  out  1  access is a write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; valid with ram_ready
- ram_ready  in  1  one-cycle completion pulse for the current access

## Operation
- States: IDLE, IBUSY, DBUSY.
- IDLE:
  - Data request = dREN|dWEN.
  - Grant data if a data request is pending and NOT (iREN && scnt==STARVE_LIMIT); otherwise grant instruction if iREN; otherwise stay in IDLE.
- Grant (registered): latch ram_addr, ram_wdata, and ram_wen.
  - Data grant: ram_addr=daddr, ram_wdata=dstore, ram_wen=dWEN. dWEN takes precedence when both dREN and dWEN are set.
  - Instruction grant: ram_addr=iaddr, ram_wdata=0, ram_wen=0.
  - Next state is DBUSY or IBUSY.
- IBUSY/DBUSY:
  - ram_req=1; latched fields are held.
  - On ram_ready, return to IDLE.
  - ram_ready in IDLE is ignored.
- Starvation counter scnt (width clog2(STARVE_LIMIT+1)), updated at grant:
  - Data grant with iREN high: scnt+1, saturating at STARVE_LIMIT.
  - Instruction grant: scnt=0.
  - IDLE with iREN low: scnt=0.
- iwait = iREN && !(state==IBUSY && ram_ready).
- dwait = (dREN|dWEN) && !(state==DBUSY && ram_ready).
- iload = dload = ram_rdata (combinational).
- A request dropped mid-access is the requester's error. The access still completes and the result is discarded.
- Reset (nRST low at an edge, including mid-access):
  - state=IDLE, scnt=0, ram_req=0, ram_wen=0, ram_addr=0, ram_wdata=0.
  - The in-flight access is abandoned. The RAM must tolerate ram_req dropping.
  - iwait and dwait stay combinational; they are high while any request is held.

## Timing
- Grant decision happens in IDLE. ram_req rises on the next cycle.
- With ram_ready asserted in cycle k of BUSY, the wait signal is low in that same cycle, the requester samples load at that edge, and the state is IDLE at k+1.
- Minimum service time for a request is 2 cycles (IDLE, then BUSY with immediate ready).
- Back-to-back accesses always have one IDLE turnaround cycle.
- ram_addr, ram_wen, and ram_wdata are stable for the whole BUSY period.
- A fetch pending continuously is granted within STARVE_LIMIT data services plus 1.

## Test plan
- Reset, then iREN=1, iaddr=0x40, RAM latency 2: ram_req high in cycles 1–2 with ram_addr=0x40, ram_wen=0; iwait low in cycle 2; iload=ram_rdata=0x2402000A.
- iREN and dREN asserted together in the same cycle (daddr=0x100): data is granted first (ram_addr=0x100), then IDLE, then the fetch is granted; iwait stays high until the second access completes.
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF: ram_wen=1, ram_wdata=0xDEADBEEF; dwait drops on ram_ready; ram_req is low the next cycle.
- STARVE_LIMIT=4, iREN held, data request re-asserted after every completion: exactly 4 data grants, then an instruction grant while data is still pending, then scnt=0 and data is granted next.
- nRST asserted during DBUSY before ram_ready: the next cycle shows ram_req=0, ram_addr=0, state IDLE. After release, the pending request is re-granted from IDLE.
- ram_ready pulsed in IDLE with no request: no state change, iwait=dwait=0, ram_req stays 0.
